dmem_responder: RTL and testbench

Data-memory responder for the RISC-V core's load/store port. It accepts one request at a time over a valid/ready handshake and inserts a fixed number of wait states. It performs byte, halfword and word stores with byte-lane merging, and returns sign- or zero-extended load data over a second valid/ready handshake. It replaces the single-cycle word-only data memory as the target side of the core's data-memory interface.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lanes.sv | 84 ++++++++
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings and FSM states.
// No logic lives here; only constants and types.
// Imported by dmem_lanes and dmem_responder.
package dmem_pkg;

   // RISC-V load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

endpackage

// File: rtl/dmem_lanes.sv
// Byte-lane steering: store byte enables / replicated write word, load extraction and extension.
// Purely combinational, zero latency.
// No flow control; misalign is only reported when DMEM_MISALIGN_TRAP_EN is defined.
module dmem_lanes
   import dmem_pkg::*;
(
   input  logic        we,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and half out of the read word
   always_comb begin
      byte_sel = rword[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
   end

   // Decode size/sign; without the trap build, low address bits below the access size are ignored
   always_comb begin
      be       = 4'b0000;
      wword    = 32'h0;
      rdata    = 32'h0;
      misalign = 1'b0;
      illegal  = 1'b0;
      if (we) begin
         case (funct3)
            F3_B: begin
               be    = 4'b0001 << addr_lo;
               wword = {4{wdata[7:0]}};
            end
            F3_H: begin
               be    = addr_lo[1] ? 4'b1100 : 4'b0011;
               wword = {2{wdata[15:0]}};
`ifdef DMEM_MISALIGN_TRAP_EN
               misalign = addr_lo[0];
`endif
            end
            F3_W: begin
               be    = 4'b1111;
               wword = wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
               misalign = |addr_lo;
`endif
            end
            default: illegal = 1'b1;
         endcase
      end else begin
         case (funct3)
            F3_B:  rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU: rdata = {24'h0, byte_sel};
            F3_H: begin
               rdata = {{16{half_sel[15]}}, half_sel};
`ifdef DMEM_MISALIGN_TRAP_EN
               misalign = addr_lo[0];
`endif
            end
            F3_HU: begin
               rdata = {16'h0, half_sel};
`ifdef DMEM_MISALIGN_TRAP_EN
               misalign = addr_lo[0];
`endif
            end
            F3_W: begin
               rdata = rword;
`ifdef DMEM_MISALIGN_TRAP_EN
               misalign = |addr_lo;
`endif
            end
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT wait states, byte/half/word lanes (DMEM_MISALIGN_TRAP_EN adds fault reporting).
// Latency: resp_valid rises WAIT+1 cycles after the accepting cycle; access happens on the last wait edge.
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WAIT  = 2
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH);

   dmem_state_t     state_q, state_d;
   logic [3:0]      cnt_q;
   logic            accept, access;

   logic            cap_we;
   logic [AW+1:0]   cap_addr;
   logic [31:0]     cap_wdata;
   logic [2:0]      cap_f3;

   logic            acc_we;
   logic [AW+1:0]   acc_addr;
   logic [31:0]     acc_wdata;
   logic [2:0]      acc_f3;

   logic [31:0]     mem [DEPTH];
   logic [31:0]     rword;
   logic [3:0]      be;
   logic [31:0]     wword, lane_rdata;
   logic            misalign, illegal, suppress, fault_err;
   logic [31:0]     resp_rdata_q;
   logic            resp_err_q;

   // Upper address bits fold away: addresses wrap modulo DEPTH*4
   logic unused_addr;
   assign unused_addr = ^req_addr[31:AW+2];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and handshake outputs; with WAIT=0 the access happens on the accepting edge
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      access     = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (WAIT == 0) begin
                  access  = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = dmem_pkg::WAIT;
               end
            end
         end
         dmem_pkg::WAIT: begin
            if (cnt_q == 4'd1) begin
               access  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Wait-state counter: loaded on accept, counts down while waiting
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          cnt_q <= 4'd0;
      else if (accept)                    cnt_q <= 4'(WAIT);
      else if (state_q == dmem_pkg::WAIT) cnt_q <= cnt_q - 4'd1;
   end

   // Capture the request so the requester is free after the handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= 32'h0;
         cap_f3    <= 3'b000;
      end else if (accept) begin
         cap_we    <= req_we;
         cap_addr  <= req_addr[AW+1:0];
         cap_wdata <= req_wdata;
         cap_f3    <= req_funct3;
      end
   end

   // Access operands: live request for a zero-wait access from IDLE, captured copy otherwise
   always_comb begin
      if (state_q == IDLE) begin
         acc_we    = req_we;
         acc_addr  = req_addr[AW+1:0];
         acc_wdata = req_wdata;
         acc_f3    = req_funct3;
      end else begin
         acc_we    = cap_we;
         acc_addr  = cap_addr;
         acc_wdata = cap_wdata;
         acc_f3    = cap_f3;
      end
   end

   assign rword = mem[acc_addr[AW+1:2]];

   dmem_lanes u_lanes (
      .we       (acc_we),
      .addr_lo  (acc_addr[1:0]),
      .funct3   (acc_f3),
      .wdata    (acc_wdata),
      .rword    (rword),
      .be       (be),
      .wword    (wword),
      .rdata    (lane_rdata),
      .misalign (misalign),
      .illegal  (illegal)
   );

   // Faulting or illegal accesses neither write nor return data
   always_comb begin
      suppress  = illegal | misalign;
`ifdef DMEM_MISALIGN_TRAP_EN
      fault_err = illegal | misalign;
`else
      fault_err = 1'b0;
`endif
   end

   // RAM write with byte-lane merge; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (access && acc_we && !suppress) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[acc_addr[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   // Response registers, updated only on the access edge so they hold through RESP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else if (access) begin
         resp_rdata_q <= (acc_we || suppress) ? 32'h0 : lane_rdata;
         resp_err_q   <= fault_err;
      end
   end

   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: WAIT=2 instance driven from a vector table plus hand sequences,
// and a WAIT=0 instance for zero-wait latency. Expectations follow DMEM_MISALIGN_TRAP_EN.
module tb_dmem_responder;
   import dmem_pkg::*;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, z_req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic [2:0]  req_funct3 = 3'b000;
   logic        resp_ready = 1'b1, z_resp_ready = 1'b1;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        z_req_ready, z_resp_valid, z_resp_err;
   logic [31:0] z_resp_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(256), .WAIT(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.DEPTH(256), .WAIT(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
      .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   localparam int NV = 22;
   vec_t vt[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full transaction with resp_ready=1; sel=1 targets the zero-wait instance.
   // lat counts negedges from the accepting cycle until resp_valid is seen.
   task automatic xact(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       output logic [31:0] rd, output logic er, output int lat);
      int n;
      @(negedge clk);
      req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
      if (sel) begin z_req_valid = 1'b1; z_resp_ready = 1'b1; end
      else     begin req_valid = 1'b1;   resp_ready = 1'b1;   end
      n = 0;
      while (!(sel ? z_req_ready : req_ready) && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      z_req_valid = 1'b0; req_valid = 1'b0;
      lat = 1;
      while (!(sel ? z_resp_valid : resp_valid) && lat < 40) begin @(negedge clk); lat++; end
      rd = sel ? z_resp_rdata : resp_rdata;
      er = sel ? z_resp_err : resp_err;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd, hold;
      logic        er;
      int          lat, n;

      vt[0]  = '{1'b1, 32'h64,  32'hDEADBEEF, F3_W,   32'h0, 1'b0};
      vt[1]  = '{1'b0, 32'h64,  32'h0,        F3_W,   32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 32'h65,  32'h00000080, F3_B,   32'h0, 1'b0};
      vt[3]  = '{1'b0, 32'h65,  32'h0,        F3_B,   32'hFFFFFF80, 1'b0};
      vt[4]  = '{1'b0, 32'h65,  32'h0,        F3_BU,  32'h00000080, 1'b0};
      vt[5]  = '{1'b0, 32'h64,  32'h0,        F3_W,   32'hDEAD80EF, 1'b0};
      vt[6]  = '{1'b1, 32'h66,  32'h00001234, F3_H,   32'h0, 1'b0};
      vt[7]  = '{1'b0, 32'h66,  32'h0,        F3_HU,  32'h00001234, 1'b0};
      vt[8]  = '{1'b0, 32'h64,  32'h0,        F3_W,   32'h123480EF, 1'b0};
      vt[9]  = '{1'b0, 32'h64,  32'h0,        F3_H,   32'hFFFF80EF, 1'b0};
      vt[10] = '{1'b0, 32'h67,  32'h0,        F3_B,   32'h00000012, 1'b0};
      vt[11] = '{1'b0, 32'h464, 32'h0,        F3_B,   32'hFFFFFFEF, 1'b0};
      vt[12] = '{1'b1, 32'h60,  32'hCAFEF00D, F3_W,   32'h0, 1'b0};
      vt[13] = '{1'b0, 32'h62,  32'h0,        F3_W,   TRAP ? 32'h0 : 32'hCAFEF00D, TRAP};
      vt[14] = '{1'b1, 32'h62,  32'h55555555, F3_W,   32'h0, TRAP};
      vt[15] = '{1'b0, 32'h60,  32'h0,        F3_W,   TRAP ? 32'hCAFEF00D : 32'h55555555, 1'b0};
      vt[16] = '{1'b0, 32'h65,  32'h0,        F3_H,   TRAP ? 32'h0 : 32'hFFFF80EF, TRAP};
      vt[17] = '{1'b0, 32'h64,  32'h0,        3'b011, 32'h0, TRAP};
      vt[18] = '{1'b1, 32'h64,  32'hFFFFFFFF, 3'b100, 32'h0, TRAP};
      vt[19] = '{1'b0, 32'h64,  32'h0,        F3_W,   32'h123480EF, 1'b0};
      vt[20] = '{1'b1, 32'h467, 32'h000000AB, F3_B,   32'h0, 1'b0};
      vt[21] = '{1'b0, 32'h64,  32'h0,        F3_W,   32'hAB3480EF, 1'b0};

      // Reset state, while asserted and after release
      #1;
      chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst resp_err", {31'h0, resp_err}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post-rst req_ready", {31'h0, req_ready}, 32'h1);
      chk("post-rst resp_valid", {31'h0, resp_valid}, 32'h0);

      // Vector table on the WAIT=2 instance
      for (int i = 0; i < NV; i++) begin
         xact(1'b0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].f3, rd, er, lat);
         chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rdata);
         chk($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vt[i].exp_err});
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      end

      // Backpressure: response held, concurrent request ignored
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h64; req_funct3 = F3_W; resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp resp_valid rise", {31'h0, resp_valid}, 32'h1);
      hold = resp_rdata;
      chk("bp rdata", hold, 32'hAB3480EF);
      req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0; req_funct3 = F3_W;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp%0d resp_valid", k), {31'h0, resp_valid}, 32'h1);
         chk($sformatf("bp%0d rdata", k), resp_rdata, 32'hAB3480EF);
         chk($sformatf("bp%0d req_ready", k), {31'h0, req_ready}, 32'h0);
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      @(negedge clk);
      chk("bp release resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("bp release req_ready", {31'h0, req_ready}, 32'h1);
      xact(1'b0, 1'b0, 32'h64, 32'h0, F3_W, rd, er, lat);
      chk("bp ignored store", rd, 32'hAB3480EF);

      // Zero-wait instance: response one cycle after accept
      xact(1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, F3_W, rd, er, lat);
      chk("w0 store latency", 32'(lat), 32'd1);
      xact(1'b1, 1'b0, 32'h12, 32'h0, F3_HU, rd, er, lat);
      chk("w0 load latency", 32'(lat), 32'd1);
      chk("w0 load rdata", rd, 32'h0000A5A5);

      // Reset during RESP drops the response at once
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h64; req_funct3 = F3_W; resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin @(negedge clk); n++; end
      chk("rresp valid before", {31'h0, resp_valid}, 32'h1);
      #1 reset = 1'b1;
      #1;
      chk("rresp resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rresp resp_rdata", resp_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0; resp_ready = 1'b1;

      // Reset during WAIT discards the pending store
      xact(1'b0, 1'b1, 32'h68, 32'hAAAA0001, F3_W, rd, er, lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h68; req_wdata = 32'h11111111; req_funct3 = F3_W;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rwait in WAIT req_ready", {31'h0, req_ready}, 32'h0);
      #1 reset = 1'b1;
      #1;
      chk("rwait req_ready", {31'h0, req_ready}, 32'h1);
      chk("rwait resp_valid", {31'h0, resp_valid}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      xact(1'b0, 1'b0, 32'h68, 32'h0, F3_W, rd, er, lat);
      chk("rwait prior value", rd, 32'hAAAA0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
